// File: rtl/voltage_pkg.sv
// Shared constants for the AD7606 voltage <-> code conversion stages:
// full-scale magnitude, code limits, ASCII sign characters and FSM encoding.
package voltage_pkg;

    localparam int          FULL_SCALE_DEF = 50000;
    localparam logic [15:0] CODE_MAX       = 16'h7FFF;
    localparam logic [15:0] CODE_MIN       = 16'h8000;

    localparam logic [7:0]  SIGN_POS       = 8'h2B;
    localparam logic [7:0]  SIGN_NEG       = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } v2c_state_e;

endpackage

// File: rtl/voltage_to_code_udiv_serial.sv
// Serial restoring divider: one quotient bit per cycle, MSB first.
// start_i loads the operands; done_o pulses for one cycle once the quotient is final.
module udiv_serial #(
    parameter int DW = 31,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          done_o,
    output logic [DW-1:0] quotient_o
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0] dvd_q;
    logic [DW-1:0] quo_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [VW:0]   rem_sh;
    logic [VW:0]   rem_d;
    logic          ge;

    // Remainder stays below the divisor, so the top bit is free for the shift-in.
    always_comb begin
        rem_sh = {rem_q[VW-1:0], dvd_q[DW-1]};
        ge     = (rem_sh >= {1'b0, divisor_i});
        rem_d  = ge ? (rem_sh - {1'b0, divisor_i}) : rem_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            dvd_q  <= dividend_i;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            dvd_q <= {dvd_q[DW-2:0], 1'b0};
            rem_q <= rem_d;
            quo_q <= {quo_q[DW-2:0], ge};
            if (cnt_q == CW'(DW - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/voltage_to_code.sv
// Sign + magnitude (0.1 mV units) to 16-bit AD7606 two's complement code.
// Build option V2C_ROUND_EN: round to nearest instead of truncating toward zero.
//
// state   | meaning
// IDLE    | ready for a request
// DIV     | serial division running
// DONE    | result presented, waiting for out_ready
module voltage_to_code
    import voltage_pkg::*;
#(
    parameter int FULL_SCALE = FULL_SCALE_DEF,
    parameter int DIV_STEPS  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_sign,
    input  logic [15:0] in_mag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_code,
    output logic        out_sat
);

`ifdef V2C_ROUND_EN
    localparam logic [DIV_STEPS-1:0] RND = DIV_STEPS'(FULL_SCALE / 2);
`else
    localparam logic [DIV_STEPS-1:0] RND = '0;
`endif
    localparam logic [DIV_STEPS-1:0] POS_LIM = DIV_STEPS'(32767);
    localparam logic [DIV_STEPS-1:0] NEG_LIM = DIV_STEPS'(32768);

    v2c_state_e           state_q, state_d;
    logic                 neg_q;
    logic [15:0]          code_q, code_d;
    logic                 sat_q, sat_d;
    logic                 accept;
    logic                 div_done;
    logic [DIV_STEPS-1:0] dividend;
    logic [DIV_STEPS-1:0] quo;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign dividend = DIV_STEPS'({in_mag, 15'd0}) + RND;

    udiv_serial #(
        .DW(DIV_STEPS),
        .VW(16)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept),
        .dividend_i (dividend),
        .divisor_i  (16'(FULL_SCALE)),
        .done_o     (div_done),
        .quotient_o (quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            neg_q   <= 1'b0;
            code_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                neg_q <= (in_sign == SIGN_NEG);
            end
            if (state_q == ST_DIV && div_done) begin
                code_q <= code_d;
                sat_q  <= sat_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)              state_d = ST_DIV;
            ST_DIV:  if (div_done)              state_d = ST_DONE;
            ST_DONE: if (out_ready)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Negative side reaches one code further (-32768) than the positive side.
    always_comb begin
        code_d = quo[15:0];
        sat_d  = 1'b0;
        if (!neg_q) begin
            if (quo > POS_LIM) begin
                code_d = CODE_MAX;
                sat_d  = 1'b1;
            end
        end else if (quo > NEG_LIM) begin
            code_d = CODE_MIN;
            sat_d  = 1'b1;
        end else begin
            code_d = (~quo[15:0]) + 16'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign out_code = code_q;
    assign out_sat  = sat_q;

endmodule

// File: tb/tb_voltage_to_code.sv
// Scoreboard bench for voltage_to_code; expectations follow V2C_ROUND_EN when defined.
module tb_voltage_to_code;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sign;
    logic [15:0] in_mag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_code;
    logic        out_sat;

    typedef struct {
        logic [15:0] code;
        logic        sat;
        int          vcyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    logic prev_v = 1'b0;

    voltage_to_code dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) first_cyc = cyc;
            prev_v = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=0x%0h required=none", out_code);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_code", int'(out_code), int'(e.code));
                    chk("out_sat", int'(out_sat), int'(e.sat));
                    chk("latency_cycle", first_cyc, e.vcyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [15:0] m,
                        input logic [15:0] code, input logic sat);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sign  = s;
        in_mag   = m;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        if (n <= 100) begin
            e.code = code;
            e.sat  = sat;
            e.vcyc = cyc + 1 + 32;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic quiet;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 8'h2B;
        in_mag    = 16'd0;
        out_ready = 1'b1;
        #23;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_code", int'(out_code), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;

        send(8'h2B, 16'd25000, 16'h4000, 1'b0);
        send(8'h2D, 16'd25000, 16'hC000, 1'b0);
`ifdef V2C_ROUND_EN
        send(8'h2B, 16'd1,     16'h0001, 1'b0);
        send(8'h2D, 16'd7,     16'hFFFB, 1'b0);
`else
        send(8'h2B, 16'd1,     16'h0000, 1'b0);
        send(8'h2D, 16'd7,     16'hFFFC, 1'b0);
`endif
        send(8'h2B, 16'd50000, 16'h7FFF, 1'b1);
        send(8'h2D, 16'd50000, 16'h8000, 1'b0);
        send(8'h2D, 16'd60000, 16'h8000, 1'b1);
        send(8'h2B, 16'd65535, 16'h7FFF, 1'b1);
        send(8'h2B, 16'd12345, 16'h1F9A, 1'b0);
        send(8'h20, 16'd25000, 16'h4000, 1'b0);
        send(8'h2D, 16'd0,     16'h0000, 1'b0);
        drain();

        // Back-pressure: result must freeze while out_ready is low.
        out_ready = 1'b0;
        send(8'h2D, 16'd25000, 16'hC000, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", int'({out_valid, in_ready, out_sat, out_code}),
                int'({1'b1, 1'b0, 1'b0, 16'hC000}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        drain();

        // Reset in the middle of a division discards the result.
        send(8'h2B, 16'd25000, 16'h4000, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_code", int'(out_code), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
        end
        chk("midrst_no_stale", int'(quiet), 1);

`ifdef V2C_ROUND_EN
        send(8'h2D, 16'd7, 16'hFFFB, 1'b0);
`else
        send(8'h2D, 16'd7, 16'hFFFC, 1'b0);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
